// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants: datapath width, register-file geometry
// and the writeback-select encoding also used by the control unit.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  // Link return outranks a load so jal/jalr always write PC+4.
  function automatic logic [1:0] wb_sel_encode(input logic ret, input logic mem_to_reg);
    if (ret)             return WB_SEL_PC4;
    else if (mem_to_reg) return WB_SEL_MEM;
    else                 return WB_SEL_ALU;
  endfunction

endpackage

// File: rtl/regfile_core.sv
// 32 x XLEN integer register file: one write port, two asynchronous read ports,
// x0 hard-wired to zero, optional write-through bypass (macro WB_BYPASS_EN).
module regfile_core #(
  parameter int               XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0]  SP_RESET = '0
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          we,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] waddr,
  input  logic [XLEN-1:0]               wdata,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] raddr1,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] raddr2,
  output logic [XLEN-1:0]               rdata1,
  output logic [XLEN-1:0]               rdata2
);
  import riscv_pkg::*;

  logic [XLEN-1:0] regs [NUM_REGS];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= (i == 2) ? SP_RESET : '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  // x0 masking is applied last so neither storage nor bypass can leak into it.
  always_comb begin
    rdata1 = regs[raddr1];
`ifdef WB_BYPASS_EN
    if (we && raddr1 == waddr) rdata1 = wdata;
`endif
    if (raddr1 == '0) rdata1 = '0;
  end

  always_comb begin
    rdata2 = regs[raddr2];
`ifdef WB_BYPASS_EN
    if (we && raddr2 == waddr) rdata2 = wdata;
`endif
    if (raddr2 == '0) rdata2 = '0;
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value, commits it to the register file
// and counts committed writes. Optional write-through bypass: WB_BYPASS_EN.
module wb_regfile #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] SP_RESET = 32'h0000_0000
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             WB_RegWrite,
  input  logic                             WB_MemtoReg,
  input  logic                             WB_return,
  input  logic [XLEN-1:0]                  WB_PC_4,
  input  logic [XLEN-1:0]                  WB_Readdata,
  input  logic [XLEN-1:0]                  WB_Address,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] WB_rd,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] ID_rs1,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] ID_rs2,
  output logic [XLEN-1:0]                  ID_rd1,
  output logic [XLEN-1:0]                  ID_rd2,
  output logic [XLEN-1:0]                  WB_data,
  output logic [63:0]                      wb_count
);
  import riscv_pkg::*;

  logic [1:0]  wb_sel;
  logic        commit;
  logic [63:0] count_q;

  assign wb_sel = wb_sel_encode(WB_return, WB_MemtoReg);

  always_comb begin
    unique case (wb_sel)
      WB_SEL_PC4: WB_data = WB_PC_4;
      WB_SEL_MEM: WB_data = WB_Readdata;
      default:    WB_data = WB_Address;
    endcase
  end

  assign commit = WB_RegWrite && (WB_rd != '0);

  regfile_core #(
    .XLEN     (XLEN),
    .SP_RESET (SP_RESET)
  ) u_core (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (WB_RegWrite),
    .waddr   (WB_rd),
    .wdata   (WB_data),
    .raddr1  (ID_rs1),
    .raddr2  (ID_rs2),
    .rdata1  (ID_rd1),
    .rdata2  (ID_rd2)
  );

  // Free-running wrap at 2^64-1 is intended; no overflow flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    count_q <= '0;
    else if (commit) count_q <= count_q + 64'd1;
  end

  assign wb_count = count_q;

endmodule
